// File: rtl/tag_stream_serializer.sv
// Serializes a multi-lane time-tag beat into one tag per cycle, decoding the
// signed channel code into index/polarity and tracking ordering, drops and count.
module tag_stream_serializer #(
  parameter int WORD_WIDTH    = 4,
  parameter int TIME_WIDTH    = 64,
  parameter int CHANNEL_WIDTH = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              s_tvalid,
  output logic                              s_tready,
  input  logic [WORD_WIDTH-1:0]             s_tkeep,
  input  logic [WORD_WIDTH*TIME_WIDTH-1:0]  s_tagtime,
  input  logic [WORD_WIDTH*CHANNEL_WIDTH-1:0] s_channel,
  output logic                              m_tvalid,
  input  logic                              m_tready,
  output logic [TIME_WIDTH-1:0]             m_time,
  output logic [CHANNEL_WIDTH-2:0]          m_index,
  output logic                              m_rising,
  output logic                              order_error,
  output logic                              chan_error,
  output logic [31:0]                       tag_count
);

  localparam int SEL_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  logic [WORD_WIDTH-1:0]    pend_q, pend_d;
  logic [TIME_WIDTH-1:0]    time_q [WORD_WIDTH];
  logic [CHANNEL_WIDTH-1:0] chan_q [WORD_WIDTH];
  logic [TIME_WIDTH-1:0]    last_time_q, last_time_d;
  logic [31:0]              tag_count_q, tag_count_d;
  logic                     order_error_q, order_error_d;
  logic                     chan_error_q, chan_error_d;

  logic [SEL_W-1:0]         sel_s;
  logic [WORD_WIDTH-1:0]    sel_onehot_s;
  logic [WORD_WIDTH-1:0]    zero_mask_s;
  logic [CHANNEL_WIDTH-1:0] sel_chan_s;
  logic                     one_left_s;
  logic                     out_hs_s;
  logic                     in_hs_s;

  // Lowest pending lane wins; scanning downward leaves the lowest index last.
  always_comb begin
    sel_s = '0;
    for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        sel_s = SEL_W'(i);
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Lanes whose channel code is zero carry no tag and are dropped on capture.
  always_comb begin
    zero_mask_s = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      zero_mask_s[i] = (s_channel[i*CHANNEL_WIDTH +: CHANNEL_WIDTH] == '0);
    end
  end

  assign sel_onehot_s = pend_q & (~pend_q + WORD_WIDTH'(1));
  assign one_left_s   = (pend_q != '0) && ((pend_q & (pend_q - WORD_WIDTH'(1))) == '0);
  assign m_tvalid     = |pend_q;
  assign out_hs_s     = m_tvalid && m_tready;
  assign s_tready     = (pend_q == '0) || (one_left_s && out_hs_s);
  assign in_hs_s      = s_tvalid && s_tready;

  // Negative codes count down from -1 as falling index 0, i.e. index = ~code.
  assign sel_chan_s = chan_q[sel_s];
  assign m_time     = time_q[sel_s];
  assign m_rising   = ~sel_chan_s[CHANNEL_WIDTH-1];
  assign m_index    = m_rising ? (sel_chan_s[CHANNEL_WIDTH-2:0] - (CHANNEL_WIDTH-1)'(1))
                               : ~sel_chan_s[CHANNEL_WIDTH-2:0];

  assign order_error = order_error_q;
  assign chan_error  = chan_error_q;
  assign tag_count   = tag_count_q;

  // Next-state for the pending mask, ordering tracker, flags and counter.
  always_comb begin
    pend_d        = pend_q;
    last_time_d   = last_time_q;
    tag_count_d   = tag_count_q;
    order_error_d = order_error_q;
    chan_error_d  = chan_error_q;
    if (out_hs_s) begin
      pend_d      = pend_q & ~sel_onehot_s;
      last_time_d = m_time;
      tag_count_d = tag_count_q + 32'd1;
      if (m_time < last_time_q) begin
        order_error_d = 1'b1;
      end else begin
        order_error_d = order_error_q;
      end
    end else begin
      pend_d = pend_q;
    end
    // A new beat replaces the mask even when the last lane leaves this cycle.
    if (in_hs_s) begin
      pend_d       = s_tkeep & ~zero_mask_s;
      chan_error_d = chan_error_q | (|(s_tkeep & zero_mask_s));
    end else begin
      chan_error_d = chan_error_d;
    end
  end

  // Control state with synchronous reset; lane data only loads on acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q        <= '0;
      last_time_q   <= '0;
      tag_count_q   <= 32'd0;
      order_error_q <= 1'b0;
      chan_error_q  <= 1'b0;
    end else begin
      pend_q        <= pend_d;
      last_time_q   <= last_time_d;
      tag_count_q   <= tag_count_d;
      order_error_q <= order_error_d;
      chan_error_q  <= chan_error_d;
      if (in_hs_s) begin
        for (int i = 0; i < WORD_WIDTH; i++) begin
          time_q[i] <= s_tagtime[i*TIME_WIDTH +: TIME_WIDTH];
          chan_q[i] <= s_channel[i*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        end
      end
    end
  end

endmodule

// File: tb/tb_tag_stream_serializer.sv
// Directed and randomized bench for tag_stream_serializer against a queue model
// of the remaining tags of the held beat.
module tb_tag_stream_serializer;

  logic         clk;
  logic         rst_n;
  logic         s_tvalid;
  logic         s_tready;
  logic [3:0]   s_tkeep;
  logic [255:0] s_tagtime;
  logic [23:0]  s_channel;
  logic         m_tvalid;
  logic         m_tready;
  logic [63:0]  m_time;
  logic [4:0]   m_index;
  logic         m_rising;
  logic         order_error;
  logic         chan_error;
  logic [31:0]  tag_count;

  tag_stream_serializer #(.WORD_WIDTH(4), .TIME_WIDTH(64), .CHANNEL_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tkeep(s_tkeep),
    .s_tagtime(s_tagtime), .s_channel(s_channel),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_time(m_time),
    .m_index(m_index), .m_rising(m_rising),
    .order_error(order_error), .chan_error(chan_error), .tag_count(tag_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] t;
    int          idx;
    bit          rise;
  } tag_t;

  tag_t        exp_q[$];
  bit          rdy_q[$];
  bit          rnd_ready;
  bit          model_ok;
  bit          accepted;
  bit          m_order;
  bit          m_chan;
  logic [63:0] m_last;
  int unsigned m_count;
  int          n_checks;
  int          n_err;
  logic [63:0] tbase;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One clock: pick m_tready, check outputs mid-cycle, advance model, cross the edge.
  task automatic step();
    bit hs;
    bit acc;
    tag_t tg;
    if (rdy_q.size() != 0) m_tready = rdy_q.pop_front();
    else if (rnd_ready)    m_tready = 1'($urandom_range(0, 1));
    else                   m_tready = 1'b1;
    #4;
    if (model_ok) begin
      chk("m_tvalid", m_tvalid, exp_q.size() != 0);
      chk("s_tready", s_tready, exp_q.size() == 0 || (exp_q.size() == 1 && m_tready));
      if (exp_q.size() != 0) begin
        chk("m_time", m_time, exp_q[0].t);
        chk("m_index", m_index, exp_q[0].idx);
        chk("m_rising", m_rising, exp_q[0].rise);
      end
      chk("tag_count", tag_count, m_count);
      chk("order_error", order_error, m_order);
      chk("chan_error", chan_error, m_chan);
    end
    if (!rst_n) begin
      exp_q.delete();
      m_last = 64'd0; m_count = 0; m_order = 1'b0; m_chan = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      hs  = (exp_q.size() != 0) && m_tready;
      acc = s_tvalid && (exp_q.size() == 0 || (exp_q.size() == 1 && hs));
      if (hs) begin
        tg = exp_q.pop_front();
        if (tg.t < m_last) m_order = 1'b1;
        m_last = tg.t;
        m_count++;
      end
      if (acc) begin
        accepted = 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (s_tkeep[i]) begin
            int c;
            c = int'(s_channel[i*6 +: 6]);
            if (c == 0) m_chan = 1'b1;
            else begin
              tg.t = s_tagtime[i*64 +: 64];
              if (c < 32) begin tg.idx = c - 1;  tg.rise = 1'b1; end
              else        begin tg.idx = 63 - c; tg.rise = 1'b0; end
              exp_q.push_back(tg);
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_beat(input logic [3:0] keep,
                          input logic [63:0] t0, input logic [63:0] t1,
                          input logic [63:0] t2, input logic [63:0] t3,
                          input logic [5:0] c0, input logic [5:0] c1,
                          input logic [5:0] c2, input logic [5:0] c3);
    s_tkeep   = keep;
    s_tagtime = {t3, t2, t1, t0};
    s_channel = {c3, c2, c1, c0};
    s_tvalid  = 1'b1;
    accepted  = 1'b0;
    for (int n = 0; n < 100 && !accepted; n++) step();
    chk("beat_accept", accepted, 64'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    s_tvalid = 1'b0;
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) step();
    chk("drain_done", exp_q.size() == 0, 64'd1);
  endtask

  initial begin
    n_checks = 0; n_err = 0; model_ok = 1'b0; rnd_ready = 1'b0;
    m_last = 64'd0; m_count = 0; m_order = 1'b0; m_chan = 1'b0;
    rst_n = 1'b0; m_tready = 1'b1;
    s_tvalid = 1'b1; s_tkeep = 4'hF;
    s_tagtime = {64'd7, 64'd6, 64'd5, 64'd4};
    s_channel = {6'd4, 6'd3, 6'd2, 6'd1};
    #1;
    for (int i = 0; i < 4; i++) step();
    s_tvalid = 1'b0;
    rst_n = 1'b1;
    step();

    // Lane serialization with a hole in lane 2.
    run_beat(4'b1011, 64'd100, 64'd200, 64'd999, 64'd400, 6'd1, 6'd2, 6'd3, 6'd4);
    drain();
    chk("serial_count", tag_count, 64'd3);

    // Decode of rising/falling codes and drop of code 0.
    run_beat(4'b1111, 64'd410, 64'd420, 64'd430, 64'd440, 6'd1, 6'd63, 6'd32, 6'd0);
    drain();

    // Backpressure, with the next beat waiting on the last lane's handshake.
    run_beat(4'b1111, 64'd450, 64'd460, 64'd470, 64'd480, 6'd5, 6'd40, 6'd31, 6'd33);
    rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1};
    run_beat(4'b0011, 64'd490, 64'd495, 64'd0, 64'd0, 6'd9, 6'd50, 6'd1, 6'd1);
    drain();

    // Times above 2^63 must still count as larger.
    run_beat(4'b0111, 64'd500, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 64'd0,
             6'd2, 6'd3, 6'd62, 6'd1);
    drain();

    // Reset after one lane leaves, then a fresh low-time beat.
    run_beat(4'b1111, 64'hF000_0000_0000_0000, 64'hF000_0000_0000_0001,
             64'hF000_0000_0000_0002, 64'hF000_0000_0000_0003, 6'd1, 6'd2, 6'd3, 6'd4);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    run_beat(4'b0001, 64'd10, 64'd0, 64'd0, 64'd0, 6'd7, 6'd0, 6'd0, 6'd0);
    drain();

    // Equal times are legal; a lower time sets the sticky flag.
    run_beat(4'b0111, 64'd500, 64'd500, 64'd499, 64'd0, 6'd1, 6'd2, 6'd3, 6'd0);
    drain();
    run_beat(4'b0001, 64'd600, 64'd0, 64'd0, 64'd0, 6'd1, 6'd0, 6'd0, 6'd0);
    drain();

    // Randomized beats and random output backpressure.
    rnd_ready = 1'b1;
    tbase = 64'd1000;
    for (int b = 0; b < 40; b++) begin
      logic [63:0] tt [4];
      logic [5:0]  cc [4];
      for (int i = 0; i < 4; i++) begin
        tbase = tbase + 64'($urandom_range(0, 20));
        tt[i] = tbase;
        cc[i] = ($urandom_range(0, 7) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
      end
      run_beat(4'($urandom_range(0, 15)), tt[0], tt[1], tt[2], tt[3], cc[0], cc[1], cc[2], cc[3]);
      if ($urandom_range(0, 3) == 0) step();
    end
    drain();
    rnd_ready = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/tag_stream_serializer.md
# tag_stream_serializer

Receives the multi-lane time-tag AXI stream (up to WORD_WIDTH tags per beat, lanes qualified by tkeep) and emits the tags one per cycle on a single-lane valid/ready stream. The block decodes the signed channel field into channel index plus edge polarity, checks that tag times are non-decreasing, and counts emitted tags. It sits directly downstream of the time-tag source, for example the stimulus generator in simulation or the FPGA-link deframer in hardware, and feeds per-tag consumers such as counters and histogrammers.

## Interface
- WORD_WIDTH, 4, tag lanes per input beat
- TIME_WIDTH, 64, tag time width in ps
- CHANNEL_WIDTH, 6, signed channel field width
- clk  in  1  system clock (312.5 MHz typical)
- rst_n  in  1  synchronous, active-low reset
- s_tvalid  in  1  input beat valid
- s_tready  out  1  input beat accepted when s_tvalid && s_tready
- s_tkeep  in  WORD_WIDTH  lane-valid mask
- s_tagtime  in  WORD_WIDTH*TIME_WIDTH  lane m at bits [m*TIME_WIDTH +: TIME_WIDTH]
- s_channel  in  WORD_WIDTH*CHANNEL_WIDTH  lane m at bits [m*CHANNEL_WIDTH +: CHANNEL_WIDTH]
- m_tvalid  out  1  output tag valid
- m_tready  in  1  output tag accepted
- m_time  out  TIME_WIDTH  tag time
- m_index  out  CHANNEL_WIDTH-1  zero-based channel index
- m_rising  out  1  1 = rising edge, 0 = falling edge
- order_error  out  1  sticky: an emitted time was lower than the previous emitted time
- chan_error  out  1  sticky: lane with channel code 0 was dropped
- tag_count  out  32  number of emitted tags, wraps modulo 2^32

## Operation
- Beat register holds `pend` (WORD_WIDTH mask), times, and channels of one accepted beat.
- s_tready = (pend == 0) || (pend has exactly one bit set && m_tready && m_tvalid). This is combinational from registers and m_tready.
- On acceptance: pend <= s_tkeep with every lane whose channel == 0 cleared. Lane data is captured. A beat with tkeep == 0 is accepted and produces nothing.
- Dropped lanes (channel == 0, tkeep bit set) set chan_error.
- Output lane = lowest set bit of pend. m_tvalid = |pend. On m_tvalid && m_tready, that bit clears.
- Channel decode of code c:
  - MSB(c) == 0 and c != 0: rising, index = c-1.
  - MSB(c) == 1: falling, index = 2^CHANNEL_WIDTH-1-c. For example, with CW=6, c=63 gives falling index 0 and c=32 gives falling index 31.
- Order check on each output handshake: if m_time < last_time, set order_error. Equal times are legal. last_time <= m_time. The comparison is unsigned over TIME_WIDTH.
- tag_count increments on each output handshake.
- Sticky flags clear only on reset.

## Timing
- Reset (rst_n low at a clk edge): pend=0, last_time=0, tag_count=0, order_error=0, chan_error=0.
- During reset: m_tvalid=0 and s_tready=1, but nothing is captured while rst_n=0.
- m_time/m_index/m_rising are don't-care while m_tvalid=0.
- Latency: beat accepted at edge N means the first tag has m_tvalid=1 in cycle N+1.
- Throughput: a beat with k live lanes drains in k cycles with m_tready held high. The next beat is accepted on the edge that consumes the last lane, so there are no bubbles between beats.
- Backpressure: while m_tready=0, the output holds all fields stable, pend is unchanged, and s_tready=0 unless pend==0.
- Reset mid-beat: remaining lanes are discarded. The first post-reset beat is treated fresh; no order check against pre-reset times.
- Flags and counter update on the same edge as the causing handshake and are visible the next cycle.

## Test plan
- Reset: hold rst_n=0 for 4 cycles with s_tvalid=1 -> m_tvalid=0, tag_count=0, both flags 0; no beat captured.
- Lane serialization: WORD_WIDTH=4, tkeep=4'b1011, times {lane0=100, 1=200, 3=400}, codes {1,2,4}, m_tready=1 -> outputs (100, idx0, rise), (200, idx1, rise), (400, idx3, rise) in consecutive cycles; s_tready low for 2 cycles then high; tag_count=3.
- Decode/drop: codes 1, 63, 32, 0 in one beat -> idx0 rising, idx0 falling, idx31 falling; lane with code 0 absent from output; chan_error=1; tag_count=3.
- Backpressure: m_tready toggling 1,0,0,1 during a 4-lane beat -> each tag held stable while stalled; no tag lost or duplicated; next beat accepted only on the final lane's handshake.
- Ordering: emit times 500, 500, 499 -> order_error stays 0 after second tag, becomes 1 after third, remains 1 after later increasing times.
- Reset mid-beat: assert rst_n=0 after 1 of 4 lanes is consumed -> m_tvalid=0 next cycle; post-reset beat with time 10 emits with order_error=0.
